twos_comp_serializer: RTL
=========================

TWOS_COMP_SERIALIZER -- requirements
Module: twos_comp_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the word width of the two's-complement result consumed from the upstream converter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH bits: the two's-complement word y from the upstream converter.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-007 SHALL have port ser_out, output, 1 bit: current serial bit, LSB first.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_out is valid.
REQ-009 SHALL have port ser_ready, input, 1 bit: downstream accepts ser_out this cycle.
REQ-010 SHALL have port ser_last, output, 1 bit: ser_out is bit WIDTH-1 (the MSB) of the frame.
REQ-011 SHALL have port ser_ovf, output, 1 bit: the held word is the most-negative value (1 followed by WIDTH-1 zeros), which has no positive counterpart; stable for the whole frame.

Function
REQ-012 SHALL implement FSM states IDLE and SHIFT only.
REQ-013 In IDLE, in_ready SHALL be 1, ser_valid 0, and ser_last 0.
REQ-014 In SHIFT, in_ready SHALL be 0 and ser_valid 1.
REQ-015 IDLE->SHIFT SHALL occur on the edge where in_valid=1 and in_ready=1; that edge loads in_data into a shift register, clears the bit counter, and registers ser_ovf.
REQ-016 Latency: the first bit (in_data[0]) SHALL appear on ser_out with ser_valid=1 in the cycle after the load edge.
REQ-017 A bit SHALL transfer only when ser_valid=1 and ser_ready=1; on transfer, the register shifts right by one and the counter increments.
REQ-018 With ser_ready=0, ser_out, ser_last, ser_ovf and the counter SHALL hold for any number of cycles.
REQ-019 ser_last SHALL be 1 exactly when the counter equals WIDTH-1 in SHIFT.
REQ-020 SHIFT->IDLE SHALL occur on transfer of the ser_last bit, so in_ready returns to 1 the following cycle; best-case throughput is one word per WIDTH+1 cycles.
REQ-021 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1; there is no wrap-around within a frame.
REQ-022 in_valid while in SHIFT SHALL be ignored; no word is dropped silently, because in_ready=0 signals backpressure upstream.
REQ-023 ser_ovf SHALL be cleared on return to IDLE.
REQ-024 ser_out in IDLE SHALL be 0.
REQ-025 in_ready SHALL be a function of state only, with no combinational path from ser_ready.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force state IDLE, shift register 0, counter 0, ser_out 0, ser_valid 0, ser_last 0, ser_ovf 0, and in_ready 1, independent of clk.
REQ-027 Reset mid-frame SHALL abandon the frame with no further serial bits; the first rising edge after rst_n deasserts SHALL behave as IDLE.

Structure
REQ-028 The state encoding (IDLE=0, SHIFT=1) and the default WIDTH SHALL live in a shared package, tc_pkg, reused by the upstream converter's wrapper.
REQ-029 No sub-module is needed; the upstream twos_complement instance SHALL be connected only at the next level up, not inside this block.

Verification
REQ-030 Reset: with rst_n=0 for 3 cycles then 1, the bench SHALL check in_ready=1, ser_valid=0, ser_out=0 and ser_ovf=0.
REQ-031 Basic frame: in_data=4'b1110 with in_valid pulsed and ser_ready=1 -> ser_out 0,1,1,1 over 4 cycles; ser_last only on the 4th; in_ready=1 on cycle 5.
REQ-032 Backpressure: in_data=4'b0110 with ser_ready=0 for cycles 2-4 -> bit 1 held constant for 3 cycles; full sequence 0,1,1,0; no bit lost or duplicated.
REQ-033 Overflow: in_data=4'b1000 -> ser_ovf=1 for all 4 bits and 0 after return to IDLE; in_data=4'b0000 -> ser_ovf=0.
REQ-034 Busy ignore: in_data=4'b0001 loaded, then in_valid=1 with 4'b1111 during SHIFT -> output stays 1,0,0,0; 4'b1111 is accepted only once in_ready=1.
REQ-035 Mid-frame reset: rst_n=0 after the 2nd bit of 4'b1010 -> outputs clear asynchronously; a new word 4'b0011 afterwards serializes cleanly as 1,1,0,0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared definitions for the two's-complement path.
// Holds the FSM encoding and default word width.
package tc_pkg;

  localparam int TC_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/twos_comp_serializer.sv
// Serializes a two's-complement word LSB first with valid/ready on both sides.
// Ports: clk, rst_n, in_data/in_valid/in_ready, ser_out/ser_valid/ser_ready, ser_last, ser_ovf.
module twos_comp_serializer
  import tc_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             ser_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  // Most-negative value: only the sign bit set.
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             load;
  logic             xfer;
  logic             at_last;

  assign in_ready  = (state == IDLE);
  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid & shreg[0];
  assign at_last   = ser_valid && (cnt == LAST_CNT);
  assign ser_last  = at_last;
  assign ser_ovf   = ovf;

  assign load = in_valid && in_ready;
  assign xfer = ser_valid && ser_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (load) state_nxt = SHIFT;
      SHIFT: if (xfer && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      shreg <= in_data;
      cnt   <= '0;
      ovf   <= (in_data == MIN_NEG);
    end else if (xfer) begin
      shreg <= shreg >> 1;
      if (at_last) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
